// File: rtl/voice_allocator_pkg.sv
// Shared types and constants for the voice allocator and its age/LRU table.
package voice_allocator_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    DECIDE = 3'd2,
    ISSUE  = 3'd3,
    HOLD   = 3'd4
  } alloc_state_t;

  // Release velocity reported when a note-on arrives with velocity 0.
  localparam logic [7:0] VEL_OFF_DEFAULT = 8'd64;

endpackage

// File: rtl/voice_age_lru.sv
// Per-voice age table: 0 = most recently assigned, VOICES-1 = oldest.
// Ages always form a permutation of 0..VOICES-1.
module voice_age_lru #(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       touch_i,
  input  logic [V_WIDTH-1:0]         touch_idx_i,
  output logic [VOICES*V_WIDTH-1:0]  age_o,
  output logic [V_WIDTH-1:0]         oldest_o
);

  logic [V_WIDTH-1:0] age_q [VOICES];
  logic [V_WIDTH-1:0] age_d [VOICES];

  // Touched voice becomes youngest; only voices younger than it move up by one.
  always_comb begin
    for (int i = 0; i < VOICES; i++) begin
      age_d[i] = age_q[i];
      if (touch_i) begin
        if (i == int'(touch_idx_i)) begin
          age_d[i] = '0;
        end else if (age_q[i] < age_q[touch_idx_i]) begin
          age_d[i] = age_q[i] + V_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < VOICES; i++) begin
        age_q[i] <= V_WIDTH'(i);
      end
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  always_comb begin
    oldest_o = '0;
    for (int i = 1; i < VOICES; i++) begin
      if (age_q[i] > age_q[oldest_o]) begin
        oldest_o = V_WIDTH'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < VOICES; i++) begin
      age_o[i*V_WIDTH +: V_WIDTH] = age_q[i];
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Maps decoded note-on/off events onto synth voices: retrigger same key, else
// lowest free voice, else steal the oldest; drives gates and current-note outputs.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int VOICES      = 8,
  parameter int V_WIDTH     = 3,
  parameter int HOLD_CYCLES = 4096
) (
  input  logic               OSC_CLK,
  input  logic               iRST,
  // Handshake: an event transfers on a rising edge where ev_valid && ev_ready;
  // ev_ready is high only while idle, and ev_on/ev_key/ev_vel must be stable with ev_valid.
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic               ev_on,
  input  logic [7:0]         ev_key,
  input  logic [7:0]         ev_vel,
  input  logic               all_off,
  input  logic [VOICES-1:0]  voice_free,
  output logic [VOICES-1:0]  keys_on,
  output logic               note_on,
  output logic [V_WIDTH-1:0] cur_key_adr,
  output logic [7:0]         cur_key_val,
  output logic [7:0]         cur_vel_on,
  output logic [7:0]         cur_vel_off,
  output logic [2:0]         dbg_state_o,
  output logic [V_WIDTH-1:0] dbg_oldest_o
);

  localparam int                 HC_W      = $clog2(HOLD_CYCLES + 1);
  localparam logic [HC_W-1:0]    HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);
  localparam logic [V_WIDTH-1:0] LAST_IDX  = V_WIDTH'(VOICES - 1);

  alloc_state_t       state_q, state_d;
  logic [V_WIDTH-1:0] idx_q, idx_d;
  logic               ev_on_q, ev_on_d;
  logic [7:0]         ev_key_q, ev_key_d;
  logic [7:0]         ev_vel_q, ev_vel_d;
  logic               match_hit_q, match_hit_d;
  logic [V_WIDTH-1:0] match_idx_q, match_idx_d;
  logic               free_hit_q, free_hit_d;
  logic [V_WIDTH-1:0] free_idx_q, free_idx_d;
  logic [V_WIDTH-1:0] old_idx_q, old_idx_d;
  logic [V_WIDTH-1:0] old_age_q, old_age_d;
  logic [V_WIDTH-1:0] target_q, target_d;
  logic [VOICES-1:0]  keys_on_q, keys_on_d;
  logic [7:0]         key_tab_q [VOICES];
  logic [7:0]         key_tab_d [VOICES];
  logic [V_WIDTH-1:0] cur_key_adr_q, cur_key_adr_d;
  logic [7:0]         cur_key_val_q, cur_key_val_d;
  logic [7:0]         cur_vel_on_q, cur_vel_on_d;
  logic [7:0]         cur_vel_off_q, cur_vel_off_d;
  logic               note_on_q, note_on_d;
  logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic               ev_ready_q, ev_ready_d;
  logic               touch;
  logic [VOICES*V_WIDTH-1:0] age_vec;
  logic [V_WIDTH-1:0] lru_oldest;
  logic [V_WIDTH-1:0] scan_age;

  voice_age_lru #(
    .VOICES  (VOICES),
    .V_WIDTH (V_WIDTH)
  ) u_lru (
    .clk_i       (OSC_CLK),
    .rst_i       (iRST),
    .touch_i     (touch),
    .touch_idx_i (target_q),
    .age_o       (age_vec),
    .oldest_o    (lru_oldest)
  );

  assign scan_age = age_vec[int'(idx_q)*V_WIDTH +: V_WIDTH];

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ev_on_d       = ev_on_q;
    ev_key_d      = ev_key_q;
    ev_vel_d      = ev_vel_q;
    match_hit_d   = match_hit_q;
    match_idx_d   = match_idx_q;
    free_hit_d    = free_hit_q;
    free_idx_d    = free_idx_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    target_d      = target_q;
    keys_on_d     = keys_on_q;
    key_tab_d     = key_tab_q;
    cur_key_adr_d = cur_key_adr_q;
    cur_key_val_d = cur_key_val_q;
    cur_vel_on_d  = cur_vel_on_q;
    cur_vel_off_d = cur_vel_off_q;
    note_on_d     = note_on_q;
    hold_cnt_d    = hold_cnt_q;
    touch         = 1'b0;

    case (state_q)
      IDLE: begin
        if (ev_valid && ev_ready_q) begin
          ev_key_d    = ev_key;
          // Zero-velocity note-on is a release at the default release velocity.
          if (ev_on && ev_vel == 8'd0) begin
            ev_on_d  = 1'b0;
            ev_vel_d = VEL_OFF_DEFAULT;
          end else begin
            ev_on_d  = ev_on;
            ev_vel_d = ev_vel;
          end
          idx_d       = '0;
          match_hit_d = 1'b0;
          free_hit_d  = 1'b0;
          old_idx_d   = '0;
          old_age_d   = '0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (!match_hit_q && keys_on_q[idx_q] && key_tab_q[idx_q] == ev_key_q) begin
          match_hit_d = 1'b1;
          match_idx_d = idx_q;
        end
        if (!free_hit_q && voice_free[idx_q] && !keys_on_q[idx_q]) begin
          free_hit_d = 1'b1;
          free_idx_d = idx_q;
        end
        if (idx_q == '0 || scan_age > old_age_q) begin
          old_idx_d = idx_q;
          old_age_d = scan_age;
        end
        idx_d = idx_q + V_WIDTH'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DECIDE;
        end
      end
      DECIDE: begin
        state_d = ISSUE;
        if (ev_on_q) begin
          if (match_hit_q)     target_d = match_idx_q;
          else if (free_hit_q) target_d = free_idx_q;
          else                 target_d = old_idx_q;
        end else if (match_hit_q) begin
          target_d = match_idx_q;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cur_key_adr_d       = target_q;
        cur_key_val_d       = ev_key_q;
        key_tab_d[target_q] = ev_key_q;
        if (ev_on_q) begin
          keys_on_d[target_q] = 1'b1;
          cur_vel_on_d        = ev_vel_q;
          touch               = 1'b1;
          note_on_d           = 1'b1;
          hold_cnt_d          = HOLD_LOAD;
          state_d             = HOLD;
        end else begin
          keys_on_d[target_q] = 1'b0;
          cur_vel_off_d       = ev_vel_q;
          state_d             = IDLE;
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) begin
          note_on_d = 1'b0;
          state_d   = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - HC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Panic release wins over everything in flight; ages and stored keys survive.
    if (all_off) begin
      keys_on_d     = '0;
      note_on_d     = 1'b0;
      touch         = 1'b0;
      key_tab_d     = key_tab_q;
      cur_key_adr_d = cur_key_adr_q;
      cur_key_val_d = cur_key_val_q;
      cur_vel_on_d  = cur_vel_on_q;
      cur_vel_off_d = cur_vel_off_q;
      if (state_q != IDLE) begin
        state_d = IDLE;
      end
    end

    ev_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge OSC_CLK or posedge iRST) begin
    if (iRST) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      ev_on_q       <= 1'b0;
      ev_key_q      <= '0;
      ev_vel_q      <= '0;
      match_hit_q   <= 1'b0;
      match_idx_q   <= '0;
      free_hit_q    <= 1'b0;
      free_idx_q    <= '0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      target_q      <= '0;
      keys_on_q     <= '0;
      for (int i = 0; i < VOICES; i++) begin
        key_tab_q[i] <= '0;
      end
      cur_key_adr_q <= '0;
      cur_key_val_q <= '0;
      cur_vel_on_q  <= '0;
      cur_vel_off_q <= '0;
      note_on_q     <= 1'b0;
      hold_cnt_q    <= '0;
      ev_ready_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      ev_on_q       <= ev_on_d;
      ev_key_q      <= ev_key_d;
      ev_vel_q      <= ev_vel_d;
      match_hit_q   <= match_hit_d;
      match_idx_q   <= match_idx_d;
      free_hit_q    <= free_hit_d;
      free_idx_q    <= free_idx_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
      target_q      <= target_d;
      keys_on_q     <= keys_on_d;
      for (int i = 0; i < VOICES; i++) begin
        key_tab_q[i] <= key_tab_d[i];
      end
      cur_key_adr_q <= cur_key_adr_d;
      cur_key_val_q <= cur_key_val_d;
      cur_vel_on_q  <= cur_vel_on_d;
      cur_vel_off_q <= cur_vel_off_d;
      note_on_q     <= note_on_d;
      hold_cnt_q    <= hold_cnt_d;
      ev_ready_q    <= ev_ready_d;
    end
  end

  assign ev_ready     = ev_ready_q;
  assign keys_on      = keys_on_q;
  assign note_on      = note_on_q;
  assign cur_key_adr  = cur_key_adr_q;
  assign cur_key_val  = cur_key_val_q;
  assign cur_vel_on   = cur_vel_on_q;
  assign cur_vel_off  = cur_vel_off_q;
  assign dbg_state_o  = state_q;
  assign dbg_oldest_o = lru_oldest;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: a full-length-hold instance for note_on timing and a
// short-hold instance for directed tables and randomized events against a recency-list model.
module tb_voice_allocator;
  import voice_allocator_pkg::*;

  localparam int VOICES    = 8;
  localparam int V_WIDTH   = 3;
  localparam int FAST_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ev_valid = 1'b0, ev_on = 1'b0, all_off = 1'b0;
  logic [7:0] ev_key = '0, ev_vel = '0, voice_free = 8'hFF;

  logic d_ev_ready, d_note_on, f_ev_ready, f_note_on;
  logic [7:0] d_keys_on, d_cur_key_val, d_cur_vel_on, d_cur_vel_off;
  logic [7:0] f_keys_on, f_cur_key_val, f_cur_vel_on, f_cur_vel_off;
  logic [2:0] d_cur_key_adr, f_cur_key_adr, d_dbg_state, f_dbg_state;
  logic [2:0] d_dbg_oldest, f_dbg_oldest;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  voice_allocator u_dut (
    .OSC_CLK(clk), .iRST(rst), .ev_valid(ev_valid), .ev_ready(d_ev_ready),
    .ev_on(ev_on), .ev_key(ev_key), .ev_vel(ev_vel), .all_off(all_off),
    .voice_free(voice_free), .keys_on(d_keys_on), .note_on(d_note_on),
    .cur_key_adr(d_cur_key_adr), .cur_key_val(d_cur_key_val),
    .cur_vel_on(d_cur_vel_on), .cur_vel_off(d_cur_vel_off),
    .dbg_state_o(d_dbg_state), .dbg_oldest_o(d_dbg_oldest)
  );

  voice_allocator #(.HOLD_CYCLES(FAST_HOLD)) u_fast (
    .OSC_CLK(clk), .iRST(rst), .ev_valid(ev_valid), .ev_ready(f_ev_ready),
    .ev_on(ev_on), .ev_key(ev_key), .ev_vel(ev_vel), .all_off(all_off),
    .voice_free(voice_free), .keys_on(f_keys_on), .note_on(f_note_on),
    .cur_key_adr(f_cur_key_adr), .cur_key_val(f_cur_key_val),
    .cur_vel_on(f_cur_vel_on), .cur_vel_off(f_cur_vel_off),
    .dbg_state_o(f_dbg_state), .dbg_oldest_o(f_dbg_oldest)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: recency list, most recent at front ----
  logic [7:0]        m_key [VOICES];
  logic [VOICES-1:0] m_on;
  int                lru_q [$];
  int                m_adr, m_kval, m_von, m_voff;

  task automatic model_reset();
    m_on = '0;
    lru_q = {};
    for (int i = 0; i < VOICES; i++) begin
      m_key[i] = '0;
      lru_q.push_back(i);
    end
    m_adr = 0; m_kval = 0; m_von = 0; m_voff = 0;
  endtask

  task automatic model_event(input logic on, input logic [7:0] key, input logic [7:0] vel,
                             input logic [7:0] vf, output logic issued);
    int t;
    t = -1;
    issued = 1'b0;
    for (int i = 0; i < VOICES; i++)
      if (t < 0 && m_on[i] && m_key[i] == key) t = i;
    if (on && vel != 0) begin
      for (int i = 0; i < VOICES; i++)
        if (t < 0 && vf[i] && !m_on[i]) t = i;
      if (t < 0) t = lru_q[$];
      for (int k = 0; k < lru_q.size(); k++)
        if (lru_q[k] == t) begin lru_q.delete(k); break; end
      lru_q.push_front(t);
      m_on[t] = 1'b1; m_key[t] = key;
      m_adr = t; m_kval = key; m_von = vel;
      issued = 1'b1;
    end else if (t >= 0) begin
      m_on[t] = 1'b0;
      m_adr = t; m_kval = key;
      m_voff = (on ? 64 : int'(vel));
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_keys_on"}, f_keys_on, m_on);
    chk({tag, "_adr"},     f_cur_key_adr, m_adr);
    chk({tag, "_key_val"}, f_cur_key_val, m_kval);
    chk({tag, "_vel_on"},  f_cur_vel_on, m_von);
    chk({tag, "_vel_off"}, f_cur_vel_off, m_voff);
    chk({tag, "_oldest"},  f_dbg_oldest, lru_q[$]);
  endtask

  // ---------------- drivers -------------------------------------------------
  task automatic do_reset();
    rst = 1'b1; ev_valid = 1'b0; all_off = 1'b0; voice_free = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_f_keys_on", f_keys_on, 0);   chk("rst_d_keys_on", d_keys_on, 0);
    chk("rst_f_note_on", f_note_on, 0);   chk("rst_d_note_on", d_note_on, 0);
    chk("rst_f_adr", f_cur_key_adr, 0);   chk("rst_d_adr", d_cur_key_adr, 0);
    chk("rst_f_kval", f_cur_key_val, 0);  chk("rst_d_kval", d_cur_key_val, 0);
    chk("rst_f_von", f_cur_vel_on, 0);    chk("rst_d_von", d_cur_vel_on, 0);
    chk("rst_f_voff", f_cur_vel_off, 0);  chk("rst_d_voff", d_cur_vel_off, 0);
    chk("rst_d_ready", d_ev_ready, 0);    chk("rst_d_state", d_dbg_state, IDLE);
    chk("rst_d_oldest", d_dbg_oldest, VOICES - 1);
    rst = 1'b0;
    #1 chk("rst_ready_low", f_ev_ready, 0);
    @(negedge clk);
    chk("rst_ready_rise", f_ev_ready, 1);
    model_reset();
  endtask

  task automatic send_event(input logic on, input logic [7:0] key, input logic [7:0] vel,
                            output logic note_seen);
    int n;
    n = 0;
    note_seen = 1'b0;
    while (f_ev_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("ready_before_event", f_ev_ready, 1);
    ev_valid = 1'b1; ev_on = on; ev_key = key; ev_vel = vel;
    @(negedge clk);
    ev_valid = 1'b0;
    n = 0;
    while (f_ev_ready !== 1'b1 && n < 100) begin
      if (f_note_on) note_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("event_done", f_ev_ready, 1);
  endtask

  task automatic pulse_all_off();
    all_off = 1'b1;
    @(negedge clk);
    all_off = 1'b0;
    chk("all_off_keys", f_keys_on, 0);
    m_on = '0;
  endtask

  task automatic start_note_wait_hold(input logic [7:0] key, input logic [7:0] vel);
    int n;
    logic iss;
    ev_valid = 1'b1; ev_on = 1'b1; ev_key = key; ev_vel = vel;
    @(negedge clk);
    ev_valid = 1'b0;
    model_event(1'b1, key, vel, voice_free, iss);
    n = 0;
    while (f_note_on !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    chk("hold_reached", f_note_on, iss);
  endtask

  // ---------------- directed table ------------------------------------------
  typedef struct {
    logic       on;
    logic [7:0] key, vel, vf, keys;
    logic [2:0] adr;
    logic [7:0] kval, von, voff;
    logic       note;
  } vec_t;

  function automatic vec_t mk(input logic on, input int key, input int vel, input int vf,
                              input int keys, input int adr, input int kval, input int von,
                              input int voff, input logic note);
    vec_t v;
    v.on = on; v.key = 8'(key); v.vel = 8'(vel); v.vf = 8'(vf); v.keys = 8'(keys);
    v.adr = 3'(adr); v.kval = 8'(kval); v.von = 8'(von); v.voff = 8'(voff); v.note = note;
    return v;
  endfunction

  vec_t tbl [15];

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic ns, mn;
    int   cnt_d, cnt_f, n;

    // fill 8 voices, steal oldest, release, drop unknown, vel-0 release, retrigger, free mask, steal
    tbl[0]  = mk(1, 60, 100, 'hFF, 'h01, 0, 60, 100, 0, 1);
    tbl[1]  = mk(1, 61, 100, 'hFF, 'h03, 1, 61, 100, 0, 1);
    tbl[2]  = mk(1, 62, 100, 'hFF, 'h07, 2, 62, 100, 0, 1);
    tbl[3]  = mk(1, 63, 100, 'hFF, 'h0F, 3, 63, 100, 0, 1);
    tbl[4]  = mk(1, 64, 100, 'hFF, 'h1F, 4, 64, 100, 0, 1);
    tbl[5]  = mk(1, 65, 100, 'hFF, 'h3F, 5, 65, 100, 0, 1);
    tbl[6]  = mk(1, 66, 100, 'hFF, 'h7F, 6, 66, 100, 0, 1);
    tbl[7]  = mk(1, 67, 100, 'hFF, 'hFF, 7, 67, 100, 0, 1);
    tbl[8]  = mk(1, 72,  90, 'hFF, 'hFF, 0, 72,  90, 0, 1);
    tbl[9]  = mk(0, 72,  40, 'hFF, 'hFE, 0, 72,  90, 40, 0);
    tbl[10] = mk(0, 50,  30, 'hFF, 'hFE, 0, 72,  90, 40, 0);
    tbl[11] = mk(1, 67,   0, 'hFF, 'h7E, 7, 67,  90, 64, 0);
    tbl[12] = mk(1, 66,  77, 'hFF, 'h7E, 6, 66,  77, 64, 1);
    tbl[13] = mk(1, 80,  10, 'hF0, 'hFE, 7, 80,  10, 64, 1);
    tbl[14] = mk(1, 81,  20, 'h00, 'hFE, 1, 81,  20, 64, 1);

    // note_on latency and exact pulse length on both instances
    do_reset();
    ev_valid = 1'b1; ev_on = 1'b1; ev_key = 8'd60; ev_vel = 8'd100;
    @(negedge clk);
    ev_valid = 1'b0;
    for (int e = 1; e <= VOICES + 1; e++) @(negedge clk);
    chk("t1_note_early", d_note_on, 0);
    chk("t1_keys_early", d_keys_on, 0);
    @(negedge clk);
    chk("t1_note_rise", d_note_on, 1);
    chk("t1_keys_on", d_keys_on, 8'h01);
    chk("t1_adr", d_cur_key_adr, 0);
    chk("t1_kval", d_cur_key_val, 60);
    chk("t1_von", d_cur_vel_on, 100);
    chk("t1_fast_keys_on", f_keys_on, 8'h01);
    cnt_d = 0; cnt_f = 0; n = 0;
    while (d_note_on === 1'b1 && n < 5000) begin
      cnt_d++;
      if (f_note_on) cnt_f++;
      @(negedge clk);
      n++;
    end
    chk("t1_note_len", cnt_d, 4096);
    chk("t1_fast_note_len", cnt_f, FAST_HOLD);
    @(negedge clk);
    chk("t1_ready_after_hold", d_ev_ready, 1);

    // table-driven sequence
    do_reset();
    for (int r = 0; r < 15; r++) begin
      voice_free = tbl[r].vf;
      send_event(tbl[r].on, tbl[r].key, tbl[r].vel, ns);
      model_event(tbl[r].on, tbl[r].key, tbl[r].vel, tbl[r].vf, mn);
      chk($sformatf("tbl%0d_keys_on", r), f_keys_on, tbl[r].keys);
      chk($sformatf("tbl%0d_adr", r), f_cur_key_adr, tbl[r].adr);
      chk($sformatf("tbl%0d_kval", r), f_cur_key_val, tbl[r].kval);
      chk($sformatf("tbl%0d_von", r), f_cur_vel_on, tbl[r].von);
      chk($sformatf("tbl%0d_voff", r), f_cur_vel_off, tbl[r].voff);
      chk($sformatf("tbl%0d_note", r), ns, tbl[r].note);
    end

    // all_off then free mask F0 lands on voice 4
    pulse_all_off();
    voice_free = 8'hF0;
    send_event(1'b1, 8'd90, 8'd50, ns);
    model_event(1'b1, 8'd90, 8'd50, voice_free, mn);
    chk("t5_adr", f_cur_key_adr, 4);
    chk("t5_keys", f_keys_on, 8'h10);
    check_model("t5");

    // all_off during SCAN drops the event
    voice_free = 8'hFF;
    ev_valid = 1'b1; ev_on = 1'b1; ev_key = 8'd91; ev_vel = 8'd33;
    @(negedge clk);
    ev_valid = 1'b0;
    @(negedge clk);
    all_off = 1'b1;
    @(negedge clk);
    all_off = 1'b0;
    m_on = '0;
    chk("t6_keys_cleared", f_keys_on, 0);
    n = 0;
    while (f_ev_ready !== 1'b1 && n < 2) begin @(negedge clk); n++; end
    chk("t6_ready_back", f_ev_ready, 1);
    chk("t6_state", f_dbg_state, IDLE);
    ns = 1'b0;
    repeat (20) begin if (f_note_on) ns = 1'b1; @(negedge clk); end
    chk("t6_no_note", ns, 0);
    check_model("t6");

    // all_off during HOLD ends note_on
    start_note_wait_hold(8'd92, 8'd44);
    all_off = 1'b1;
    @(negedge clk);
    all_off = 1'b0;
    m_on = '0;
    chk("hold_abort_note", f_note_on, 0);
    chk("hold_abort_keys", f_keys_on, 0);
    @(negedge clk);
    check_model("hold_abort");

    // iRST during HOLD: immediate reset values
    start_note_wait_hold(8'd93, 8'd45);
    rst = 1'b1;
    #1;
    chk("irst_note", f_note_on, 0);
    chk("irst_keys", f_keys_on, 0);
    chk("irst_adr", f_cur_key_adr, 0);
    chk("irst_kval", f_cur_key_val, 0);
    chk("irst_von", f_cur_vel_on, 0);
    chk("irst_ready", f_ev_ready, 0);

    // randomized events against the model
    do_reset();
    for (int i = 0; i < 150; i++) begin
      logic       r_on;
      logic [7:0] r_key, r_vel;
      if ($urandom_range(0, 11) == 0) begin
        pulse_all_off();
        @(negedge clk);
      end else begin
        voice_free = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
        r_on  = ($urandom_range(0, 2) != 0);
        r_key = 8'(60 + $urandom_range(0, 9));
        r_vel = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 127));
        send_event(r_on, r_key, r_vel, ns);
        model_event(r_on, r_key, r_vel, voice_free, mn);
        chk($sformatf("rnd%0d_note", i), ns, mn);
        check_model($sformatf("rnd%0d", i));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
